// File: rtl/wb_stage_pkg.sv
// Shared definitions for the wb_stage writeback block: FSM encoding, default widths
// and the {rd, data} writeback entry layout.
package wb_stage_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int REG_AW_DEF = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    WAIT_LOAD = 2'b01
  } wb_state_e;

  typedef struct packed {
    logic [REG_AW_DEF-1:0] rd;
    logic [XLEN_DEF-1:0]   data;
  } wb_entry_t;

endpackage

// File: rtl/wb_stage_if.sv
// Bus bundle between the LSU/EX producers, the controller and wb_stage.
// The forwarding signals exist only when WB_BYPASS_EN is defined.
interface wb_stage_if import wb_stage_pkg::*; #(
  parameter int REG_AW    = REG_AW_DEF,
  parameter int XLEN      = XLEN_DEF,
  parameter int BUF_DEPTH = 2
);
  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

  logic              load_issue_i;
  logic [REG_AW-1:0] load_rd_i;
  logic              lsu_wb_flag_i;
  logic [XLEN-1:0]   lsu_wdata_i;
  logic              alu_wb_flag_i;
  logic [REG_AW-1:0] alu_rd_i;
  logic [XLEN-1:0]   alu_wdata_i;
  logic              rf_we_o;
  logic [REG_AW-1:0] rf_waddr_o;
  logic [XLEN-1:0]   rf_wdata_o;
  logic              wb_hold_o;
  logic              wb_err_o;
  logic [CNT_W-1:0]  buf_cnt_o;
`ifdef WB_BYPASS_EN
  logic              fwd_valid_o;
  logic [REG_AW-1:0] fwd_rd_o;
  logic [XLEN-1:0]   fwd_data_o;
`endif

  modport master (
`ifdef WB_BYPASS_EN
    input  fwd_valid_o, fwd_rd_o, fwd_data_o,
`endif
    output load_issue_i, load_rd_i, lsu_wb_flag_i, lsu_wdata_i,
    output alu_wb_flag_i, alu_rd_i, alu_wdata_i,
    input  rf_we_o, rf_waddr_o, rf_wdata_o, wb_hold_o, wb_err_o, buf_cnt_o
  );

  modport slave (
`ifdef WB_BYPASS_EN
    output fwd_valid_o, fwd_rd_o, fwd_data_o,
`endif
    input  load_issue_i, load_rd_i, lsu_wb_flag_i, lsu_wdata_i,
    input  alu_wb_flag_i, alu_rd_i, alu_wdata_i,
    output rf_we_o, rf_waddr_o, rf_wdata_o, wb_hold_o, wb_err_o, buf_cnt_o
  );

endinterface

// File: rtl/wb_stage_skid_fifo.sv
// wb_skid_fifo: small synchronous FIFO parking ALU results that lost the write port.
// Caller guarantees no push when full without a pop, and no pop when empty.
module wb_skid_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once count says they are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  assign rdata = mem[rptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: owns the single regfile write port, pairs issued loads with the LSU
// result pulse and skids colliding ALU results. Optional macro WB_BYPASS_EN adds forwarding.
module wb_stage import wb_stage_pkg::*; #(
  parameter int REG_AW       = REG_AW_DEF,
  parameter int XLEN         = XLEN_DEF,
  parameter int BUF_DEPTH    = 2,
  parameter int LOAD_TIMEOUT = 15
) (
  input logic       clk,
  input logic       rst_n,
  wb_stage_if.slave bus
);

  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
  localparam int TMO_W = $clog2(LOAD_TIMEOUT + 1);

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } entry_t;

  wb_state_e         state;
  wb_state_e         state_nx;
  logic [REG_AW-1:0] pend_rd;
  logic [TMO_W-1:0]  tmo_cnt;

  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_cnt;
  entry_t            fifo_head;
  entry_t            alu_entry;
  entry_t            sel_entry;

  logic              load_accept;
  logic              lsu_take;
  logic              tmo_hit;
  logic              fifo_pop;
  logic              fifo_push;
  logic              alu_direct;
  logic              sel_valid;
  logic              err_set;

  assign alu_entry = {bus.alu_rd_i, bus.alu_wdata_i};

  wb_skid_fifo #(
    .WIDTH (REG_AW + XLEN),
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (alu_entry),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  // A load is only accepted with the skid FIFO empty, so LSU-first priority keeps program order.
  always_comb begin
    state_nx    = state;
    load_accept = 1'b0;
    lsu_take    = 1'b0;
    tmo_hit     = 1'b0;
    err_set     = 1'b0;
    fifo_pop    = 1'b0;
    fifo_push   = 1'b0;
    alu_direct  = 1'b0;
    sel_valid   = 1'b0;
    sel_entry   = '0;

    case (state)
      IDLE: begin
        if (bus.load_issue_i && fifo_empty) begin
          load_accept = 1'b1;
          state_nx    = WAIT_LOAD;
        end
        if (bus.lsu_wb_flag_i) err_set = 1'b1;
      end
      WAIT_LOAD: begin
        if (bus.lsu_wb_flag_i) begin
          lsu_take = 1'b1;
          state_nx = IDLE;
        end else if (tmo_cnt == TMO_W'(LOAD_TIMEOUT - 1)) begin
          tmo_hit  = 1'b1;
          state_nx = IDLE;
        end
        if (bus.load_issue_i) err_set = 1'b1;
      end
      default: state_nx = IDLE;
    endcase

    fifo_pop   = !lsu_take && !fifo_empty;
    alu_direct = bus.alu_wb_flag_i && !lsu_take && fifo_empty;
    fifo_push  = bus.alu_wb_flag_i && !alu_direct && (!fifo_full || fifo_pop);
    if (bus.alu_wb_flag_i && !alu_direct && fifo_full && !fifo_pop) err_set = 1'b1;
    if (tmo_hit) err_set = 1'b1;

    if (lsu_take) begin
      sel_valid      = 1'b1;
      sel_entry.rd   = pend_rd;
      sel_entry.data = bus.lsu_wdata_i;
    end else if (fifo_pop) begin
      sel_valid = 1'b1;
      sel_entry = fifo_head;
    end else if (alu_direct) begin
      sel_valid = 1'b1;
      sel_entry = alu_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      pend_rd        <= '0;
      tmo_cnt        <= '0;
      bus.rf_we_o    <= 1'b0;
      bus.rf_waddr_o <= '0;
      bus.rf_wdata_o <= '0;
      bus.wb_err_o   <= 1'b0;
    end else begin
      state <= state_nx;
      if (load_accept) pend_rd <= bus.load_rd_i;
      if ((state == WAIT_LOAD) && (state_nx == WAIT_LOAD)) tmo_cnt <= tmo_cnt + TMO_W'(1);
      else                                                 tmo_cnt <= '0;
      // x0 targets are consumed but never written; address/data keep their last values.
      if (sel_valid && (sel_entry.rd != '0)) begin
        bus.rf_we_o    <= 1'b1;
        bus.rf_waddr_o <= sel_entry.rd;
        bus.rf_wdata_o <= sel_entry.data;
      end else begin
        bus.rf_we_o <= 1'b0;
      end
      if (err_set) bus.wb_err_o <= 1'b1;
    end
  end

  assign bus.wb_hold_o = fifo_full || (bus.load_issue_i && !fifo_empty && (state == IDLE));
  assign bus.buf_cnt_o = fifo_cnt;

`ifdef WB_BYPASS_EN
  assign bus.fwd_valid_o = sel_valid && (sel_entry.rd != '0);
  assign bus.fwd_rd_o    = sel_entry.rd;
  assign bus.fwd_data_o  = sel_entry.data;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios followed by random traffic,
// compared against a queue-based behavioural model of the writeback rules.
module tb_wb_stage;
  import wb_stage_pkg::*;

  localparam int BUF_DEPTH    = 2;
  localparam int LOAD_TIMEOUT = 15;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  wb_stage_if #(.REG_AW(4), .XLEN(32), .BUF_DEPTH(BUF_DEPTH)) bus ();

  wb_stage #(
    .REG_AW       (4),
    .XLEN         (32),
    .BUF_DEPTH    (BUF_DEPTH),
    .LOAD_TIMEOUT (LOAD_TIMEOUT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Model: a pending load (rd + cycles waited), an ordered list of parked ALU results,
  // the last regfile write and the sticky error.
  bit          m_pend;
  int          m_wait;
  logic [3:0]  m_pend_rd;
  wb_entry_t   m_q[$];
  bit          m_we;
  logic [3:0]  m_waddr;
  logic [31:0] m_wdata;
  bit          m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_output();
    check("rf_we",    {31'b0, bus.rf_we_o}, {31'b0, m_we});
    check("rf_waddr", {28'b0, bus.rf_waddr_o}, {28'b0, m_waddr});
    check("rf_wdata", bus.rf_wdata_o, m_wdata);
    check("wb_err",   {31'b0, bus.wb_err_o}, {31'b0, m_err});
    check("buf_cnt",  32'(bus.buf_cnt_o), 32'(m_q.size()));
  endtask

  task automatic model_step(input bit issue, input logic [3:0] rd, input bit lsu,
                            input logic [31:0] ldata, input bit alu,
                            input logic [3:0] ard, input logic [31:0] adata);
    bit        pend0;
    int        q0;
    bit        wrote;
    wb_entry_t w;
    wb_entry_t a;
    pend0 = m_pend;
    q0    = m_q.size();
    wrote = 1'b0;
    w     = '0;
    if (pend0 && lsu) begin
      w.rd = m_pend_rd; w.data = ldata; wrote = 1'b1; m_pend = 1'b0;
    end else if (!pend0 && lsu) begin
      m_err = 1'b1;
    end
    if (pend0 && !lsu) begin
      m_wait++;
      if (m_wait == LOAD_TIMEOUT) begin m_err = 1'b1; m_pend = 1'b0; end
    end
    // Every ALU result joins the tail; the free write slot (if any) takes the oldest one.
    if (alu) begin
      a.rd = ard; a.data = adata;
      if (q0 < BUF_DEPTH || !wrote) m_q.push_back(a);
      else m_err = 1'b1;
    end
    if (!wrote && m_q.size() > 0) begin w = m_q.pop_front(); wrote = 1'b1; end
    if (issue) begin
      if (pend0) m_err = 1'b1;
      else if (q0 == 0) begin m_pend = 1'b1; m_pend_rd = rd; m_wait = 0; end
    end
    m_we = wrote && (w.rd != 4'd0);
    if (m_we) begin m_waddr = w.rd; m_wdata = w.data; end
  endtask

  task automatic apply_stimulus(input bit issue, input logic [3:0] rd, input bit lsu,
                                input logic [31:0] ldata, input bit alu,
                                input logic [3:0] ard, input logic [31:0] adata);
    bit exp_hold;
    bus.load_issue_i  = issue;
    bus.load_rd_i     = rd;
    bus.lsu_wb_flag_i = lsu;
    bus.lsu_wdata_i   = ldata;
    bus.alu_wb_flag_i = alu;
    bus.alu_rd_i      = ard;
    bus.alu_wdata_i   = adata;
    exp_hold = (m_q.size() == BUF_DEPTH) || (issue && m_q.size() != 0 && !m_pend);
    #2;
    check("wb_hold", {31'b0, bus.wb_hold_o}, {31'b0, exp_hold});
    @(posedge clk);
    model_step(issue, rd, lsu, ldata, alu, ard, adata);
    #1;
    check_output();
  endtask

  task automatic idle_step();
    apply_stimulus(1'b0, 4'd0, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.load_issue_i = 1'b0; bus.load_rd_i = '0; bus.lsu_wb_flag_i = 1'b0; bus.lsu_wdata_i = '0;
    bus.alu_wb_flag_i = 1'b0; bus.alu_rd_i = '0; bus.alu_wdata_i = '0;
    #1;
    m_pend = 1'b0; m_wait = 0; m_q.delete(); m_we = 1'b0; m_waddr = '0; m_wdata = '0; m_err = 1'b0;
    check_output();
    check("wb_hold_rst", {31'b0, bus.wb_hold_o}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #1;
    do_reset();

    $display("[TB] load path");
    apply_stimulus(1'b1, 4'd5, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0);
    apply_stimulus(1'b0, 4'd0, 1'b1, 32'hDEADBEEF, 1'b0, 4'd0, 32'd0);
    idle_step();

    $display("[TB] LSU/ALU collision");
    apply_stimulus(1'b1, 4'd3, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0);
    apply_stimulus(1'b0, 4'd0, 1'b1, 32'h12345678, 1'b1, 4'd7, 32'h11);
    idle_step();

    $display("[TB] load blocked by parked ALU result");
    apply_stimulus(1'b1, 4'd2, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0);
    apply_stimulus(1'b0, 4'd0, 1'b1, 32'h0000AAAA, 1'b1, 4'd8, 32'h22);
    apply_stimulus(1'b1, 4'd9, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0);
    apply_stimulus(1'b1, 4'd9, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0);
    apply_stimulus(1'b0, 4'd0, 1'b1, 32'hCAFE0009, 1'b0, 4'd0, 32'd0);

    $display("[TB] direct ALU and x0 writes");
    apply_stimulus(1'b0, 4'd0, 1'b0, 32'd0, 1'b1, 4'd10, 32'h0BADF00D);
    apply_stimulus(1'b0, 4'd0, 1'b0, 32'd0, 1'b1, 4'd0, 32'h55);
    idle_step();

    $display("[TB] load timeout");
    apply_stimulus(1'b1, 4'd12, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0);
    for (int i = 0; i < LOAD_TIMEOUT; i++) idle_step();
    apply_stimulus(1'b0, 4'd0, 1'b1, 32'h77, 1'b0, 4'd0, 32'd0);

    $display("[TB] reset mid-load then stray LSU pulse");
    do_reset();
    apply_stimulus(1'b1, 4'd4, 1'b0, 32'd0, 1'b1, 4'd6, 32'h66);
    do_reset();
    apply_stimulus(1'b0, 4'd0, 1'b1, 32'h99, 1'b0, 4'd0, 32'd0);
    idle_step();

    $display("[TB] random traffic");
    do_reset();
    for (int n = 0; n < 400; n++) begin
      bit          issue;
      bit          lsu;
      bit          alu;
      logic [3:0]  rd;
      logic [3:0]  ard;
      logic [31:0] ldata;
      logic [31:0] adata;
      issue = ($urandom_range(0, 3) == 0);
      rd    = 4'($urandom_range(0, 15));
      lsu   = (m_pend && m_wait == 0) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 31) == 0);
      ldata = $urandom;
      alu   = ($urandom_range(0, 1) == 1);
      ard   = 4'($urandom_range(0, 15));
      adata = $urandom;
      apply_stimulus(issue, rd, lsu, ldata, alu, ard, adata);
      if (n == 199) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
